mips_divider: RTL and testbench

Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU. It runs the inverse of the datapath's add/subtract path: one trial subtraction per cycle over 32 iterations. It produces quotient (LO) and remainder (HI) for the HI/LO register file. The control unit stalls the pipeline while busy is high.

---
 rtl/mips_divider.sv | 113 +++++++++++
 tb/tb_mips_divider.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_divider.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Produces quotient (LO) and remainder (HI) 33 cycles after start is accepted.
module mips_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    logic             op_signed;
    logic             dvd_neg;
    logic             dvs_neg;
    logic             dvs_zero;
    logic [WIDTH-1:0] dvd_raw;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [CW-1:0]    count;

    logic [WIDTH+1:0] trial;
    logic             trial_neg;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Trial subtraction on the shifted {rem, quo}; top bit is the borrow.
    always_comb begin
        trial     = {1'b0, rem, quo[WIDTH-1]} - {2'b00, dvs_mag};
        trial_neg = trial[WIDTH+1];
        q_fix     = quo;
        r_fix     = rem[WIDTH-1:0];
        if (dvs_zero) begin
            q_fix = '1;
            r_fix = dvd_raw;
        end else if (op_signed) begin
            if (dvd_neg ^ dvs_neg) q_fix = -quo;
            if (dvd_neg)           r_fix = -rem[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_signed   <= 1'b0;
            dvd_neg     <= 1'b0;
            dvs_neg     <= 1'b0;
            dvs_zero    <= 1'b0;
            dvd_raw     <= '0;
            dvs_mag     <= '0;
            rem         <= '0;
            quo         <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_signed <= is_signed;
                        dvd_neg   <= is_signed & dividend[WIDTH-1];
                        dvs_neg   <= is_signed & divisor[WIDTH-1];
                        dvs_zero  <= (divisor == '0);
                        dvd_raw   <= dividend;
                        // Quotient register starts out holding the dividend magnitude.
                        quo       <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
                        dvs_mag   <= (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
                        rem       <= '0;
                        count     <= '0;
                        busy      <= 1'b1;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    if (trial_neg) begin
                        rem <= {rem[WIDTH-1:0], quo[WIDTH-1]};
                    end else begin
                        rem <= trial[WIDTH:0];
                    end
                    quo   <= {quo[WIDTH-2:0], ~trial_neg};
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    quotient    <= q_fix;
                    remainder   <= r_fix;
                    div_by_zero <= dvs_zero;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_divider.sv
// Randomized scoreboard bench for mips_divider: driver pushes expected results,
// monitor pops and compares on every done pulse and checks results are held otherwise.
module tb_mips_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    mips_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state: {div_by_zero, quotient, remainder} and due cycle
    logic [2*W:0] exp_q[$];
    int           due_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [2*W:0] last_res = '0;

    task automatic check(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain integer division, MIPS corner cases spelled out.
    function automatic logic [2*W:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == 0) return {1'b1, {W{1'b1}}, a};
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {1'b0, q, r};
    endfunction

    // monitor
    always @(negedge clk) begin
        if (rst) begin
            last_res = '0;
        end else if (done) begin
            check("busy_low_at_done", {64'b0, busy}, '0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", {div_by_zero, quotient, remainder}, 'x);
            end else begin
                logic [2*W:0] e;
                int d;
                e = exp_q.pop_front();
                d = due_q.pop_front();
                check("result", {div_by_zero, quotient, remainder}, e);
                check("done_latency", 65'(cyc), 65'(d));
                last_res = e;
            end
        end else begin
            check("held", {div_by_zero, quotient, remainder}, last_res);
        end
    end

    // driver tasks (all input changes at negedge)
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", {64'b0, busy}, '0);
    endtask

    task automatic issue_now(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        exp_q.push_back(model(s, a, b));
        due_q.push_back(cyc + 34);
        @(negedge clk);
        start     = 1'b0;
        is_signed = $urandom_range(0, 1);
        dividend  = $urandom;
        divisor   = $urandom;
        check("busy_after_start", {64'b0, busy}, 65'd1);
    endtask

    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        wait_idle();
        issue_now(s, a, b);
    endtask

    logic [W-1:0] ra, rb;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, div_by_zero, quotient, remainder}, '0);
        rst = 1'b0;
        @(negedge clk);

        issue(0, 100, 7);
        issue(1, 32'hFFFF_FFF9, 32'h2);
        issue(1, 32'h7, 32'hFFFF_FFFE);
        issue(1, 32'h1234_5678, 32'h0);
        issue(0, 32'h1234_5678, 32'h0);
        issue(1, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(0, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(1, 32'h0, 32'h5);
        issue(0, 32'h3, 32'hA);
        issue(1, 32'hFFFF_FFFD, 32'hA);
        issue(0, 32'hFFFF_FFFF, 32'h1);

        // start pulses while busy must be ignored
        issue(0, 1000, 3);
        repeat (4) @(negedge clk);
        start = 1'b1; dividend = 77; divisor = 5;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        start = 1'b1; dividend = 99; divisor = 4;
        @(negedge clk);
        start = 1'b0;

        // start in the done cycle is accepted back-to-back
        begin
            int n = 0;
            while (!done && n < 60) begin
                @(negedge clk);
                n++;
            end
            if (!done) check("done_timeout", {64'b0, done}, 65'd1);
        end
        issue_now(1, 32'hFFFF_FF00, 32'h7);

        // reset during CALC aborts with no done
        issue(0, 32'hDEAD_BEEF, 32'h13);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        void'(exp_q.pop_back());
        void'(due_q.pop_back());
        @(negedge clk);
        check("abort_outputs", {busy, done, div_by_zero, quotient, remainder}, '0);
        rst = 1'b0;
        @(negedge clk);
        issue(0, 50, 6);

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       rb = 0;
                1, 2, 3: rb = $urandom_range(1, 20);
                4:       rb = -$urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       ra = $urandom_range(0, 100);
                1:       ra = -$urandom_range(0, 100);
                default: ra = $urandom;
            endcase
            issue($urandom_range(0, 1), ra, rb);
        end

        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            while (exp_q.size() != 0) begin
                check("missing_done", '0, exp_q.pop_front());
                void'(due_q.pop_front());
            end
        end
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
